// File: rtl/score_bcd_ctrl_pkg.sv
// Shared definitions for the scoreboard display path.
// Digit codes are common with the downstream dual 7-segment driver:
//   0..9 = BCD digit, CODE_BLANK = segments off, CODE_P = letter 'P'.
package scoreboard_pkg;

  localparam logic [3:0] CODE_BLANK    = 4'd10;
  localparam logic [3:0] CODE_P        = 4'd11;
  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

  typedef enum logic {
    SCORE = 1'b0,
    SHOW  = 1'b1
  } state_e;

  // Tens-digit code with optional leading-zero blanking.
  function automatic logic [3:0] tens_code(input logic [3:0] tens, input logic blank);
    return (blank && (tens == 4'd0)) ? CODE_BLANK : tens;
  endfunction

endpackage

// File: rtl/score_bcd_ctrl_if.sv
// Request/display bundle between the score keeper and its surroundings.
//   inc_i/dec_i/clr_i : level requests (debounced, clk-synchronous)
//   player_sel_i      : active player select (0 = P1, 1 = P2)
//   tens_o/ones_o     : digit codes to the 7-segment driver
//   player_o          : registered active player
// master = request source / display consumer, slave = score_bcd_ctrl.
interface score_bcd_ctrl_if;

  logic       inc_i;
  logic       dec_i;
  logic       clr_i;
  logic       player_sel_i;
  logic [3:0] tens_o;
  logic [3:0] ones_o;
  logic       player_o;

  modport master (
    output inc_i, dec_i, clr_i, player_sel_i,
    input  tens_o, ones_o, player_o
  );

  modport slave (
    input  inc_i, dec_i, clr_i, player_sel_i,
    output tens_o, ones_o, player_o
  );

endinterface

// File: rtl/score_bcd_ctrl_bcd_score_reg.sv
// Two-digit saturating BCD score register (00..99).
//   clk_i, rst_i       : clock, synchronous active-high reset (score -> 00)
//   inc, dec, clr      : single-cycle enables; clr wins, inc+dec together is a no-op
//   tens, ones         : registered score digits
//   tens_nxt, ones_nxt : next-state digits, so a parent can register a display
//                        copy that updates on the same edge as the score
module bcd_score_reg
  import scoreboard_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       inc,
  input  logic       dec,
  input  logic       clr,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic [3:0] tens_nxt,
  output logic [3:0] ones_nxt
);

  logic at_max;
  logic at_min;

  assign at_max = (tens == BCD_MAX_DIGIT) && (ones == BCD_MAX_DIGIT);
  assign at_min = (tens == 4'd0) && (ones == 4'd0);

  always_comb begin
    tens_nxt = tens;
    ones_nxt = ones;
    if (clr) begin
      tens_nxt = '0;
      ones_nxt = '0;
    end else if (inc && !dec && !at_max) begin
      if (ones == BCD_MAX_DIGIT) begin
        ones_nxt = '0;
        tens_nxt = tens + 4'd1;
      end else begin
        ones_nxt = ones + 4'd1;
      end
    end else if (dec && !inc && !at_min) begin
      if (ones == 4'd0) begin
        ones_nxt = BCD_MAX_DIGIT;
        tens_nxt = tens - 4'd1;
      end else begin
        ones_nxt = ones - 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tens <= '0;
      ones <= '0;
    end else begin
      tens <= tens_nxt;
      ones <= ones_nxt;
    end
  end

endmodule

// File: rtl/score_bcd_ctrl.sv
// Two-player BCD score keeper feeding the dual 7-segment driver.
//   clk_i : clock
//   rst_i : synchronous active-high reset
//   bus   : slave side of score_bcd_ctrl_if (requests in, digit codes out)
// Requests act on their rising edge and only on the active player. A player
// change shows "P1"/"P2" for SHOW_CYCLES cycles unless a request arrives.
module score_bcd_ctrl
  import scoreboard_pkg::*;
#(
  parameter int unsigned SHOW_CYCLES   = 1000000,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input logic             clk_i,
  input logic             rst_i,
  score_bcd_ctrl_if.slave bus
);

  localparam int unsigned CW = (SHOW_CYCLES > 0 && $clog2(SHOW_CYCLES + 1) > 0)
                               ? $clog2(SHOW_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LOAD = (SHOW_CYCLES > 0) ? CW'(SHOW_CYCLES - 1) : '0;

  logic          inc_prev, dec_prev, clr_prev;
  logic          inc_ev, dec_ev, clr_ev, any_ev;
  logic          player_q, player_nxt, player_chg;
  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          show_start, show_hold, show_nxt;

  logic [3:0] p1_tens, p1_ones, p1_tens_nxt, p1_ones_nxt;
  logic [3:0] p2_tens, p2_ones, p2_tens_nxt, p2_ones_nxt;
  logic [3:0] act_tens_nxt, act_ones_nxt;

  assign inc_ev = bus.inc_i & ~inc_prev;
  assign dec_ev = bus.dec_i & ~dec_prev;
  assign clr_ev = bus.clr_i & ~clr_prev;
  assign any_ev = inc_ev | dec_ev | clr_ev;

  // Events target the player as updated this cycle, not the stale register.
  assign player_chg = bus.player_sel_i != player_q;
  assign player_nxt = bus.player_sel_i;

  bcd_score_reg u_p1 (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .inc      (inc_ev & ~player_nxt),
    .dec      (dec_ev & ~player_nxt),
    .clr      (clr_ev & ~player_nxt),
    .tens     (p1_tens),
    .ones     (p1_ones),
    .tens_nxt (p1_tens_nxt),
    .ones_nxt (p1_ones_nxt)
  );

  bcd_score_reg u_p2 (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .inc      (inc_ev & player_nxt),
    .dec      (dec_ev & player_nxt),
    .clr      (clr_ev & player_nxt),
    .tens     (p2_tens),
    .ones     (p2_ones),
    .tens_nxt (p2_tens_nxt),
    .ones_nxt (p2_ones_nxt)
  );

  assign act_tens_nxt = player_nxt ? p2_tens_nxt : p1_tens_nxt;
  assign act_ones_nxt = player_nxt ? p2_ones_nxt : p1_ones_nxt;

  // Whether the indicator is on after this edge; drives the registered
  // outputs so the display switches on the same edge as the state.
  // A request always wins over starting/continuing the indicator.
  assign show_start = (state_q == SCORE) && player_chg && !any_ev && (SHOW_CYCLES != 0);
  assign show_hold  = (state_q == SHOW) && !any_ev && (player_chg || (cnt_q != '0));
  assign show_nxt   = show_start || show_hold;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inc_prev     <= 1'b0;
      dec_prev     <= 1'b0;
      clr_prev     <= 1'b0;
      player_q     <= bus.player_sel_i;
      state_q      <= SCORE;
      cnt_q        <= '0;
      bus.tens_o   <= BLANK_LEADING ? CODE_BLANK : 4'd0;
      bus.ones_o   <= '0;
      bus.player_o <= bus.player_sel_i;
    end else begin
      inc_prev     <= bus.inc_i;
      dec_prev     <= bus.dec_i;
      clr_prev     <= bus.clr_i;
      player_q     <= player_nxt;
      bus.player_o <= player_nxt;

      case (state_q)
        SCORE: begin
          if (show_start) begin
            state_q <= SHOW;
            cnt_q   <= CNT_LOAD;
          end
        end
        SHOW: begin
          if (!show_hold) begin
            state_q <= SCORE;
            cnt_q   <= '0;
          end else if (player_chg) begin
            cnt_q <= CNT_LOAD;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: begin
          state_q <= SCORE;
          cnt_q   <= '0;
        end
      endcase

      if (show_nxt) begin
        bus.tens_o <= CODE_P;
        bus.ones_o <= player_nxt ? 4'd2 : 4'd1;
      end else begin
        bus.tens_o <= tens_code(act_tens_nxt, BLANK_LEADING);
        bus.ones_o <= act_ones_nxt;
      end
    end
  end

endmodule

// File: tb/tb_score_bcd_ctrl.sv
module tb_score_bcd_ctrl;

  localparam int SHOW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  score_bcd_ctrl_if bus ();

  score_bcd_ctrl #(
    .SHOW_CYCLES   (SHOW),
    .BLANK_LEADING (1'b1)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference: scores as plain integers 0..99, indicator as cycles remaining.
  int m_score [2];
  int m_player;
  int m_show;
  bit m_pi, m_pd, m_pc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit i, input bit d, input bit c, input bit s);
    bit ei, ed, ec, chg;
    if (r) begin
      m_score[0] = 0; m_score[1] = 0;
      m_pi = 0; m_pd = 0; m_pc = 0;
      m_player = int'(s);
      m_show = 0;
      return;
    end
    ei = i && !m_pi; ed = d && !m_pd; ec = c && !m_pc;
    m_pi = i; m_pd = d; m_pc = c;
    chg = (int'(s) != m_player);
    m_player = int'(s);
    if (ec)             m_score[m_player] = 0;
    else if (ei && !ed) m_score[m_player] = (m_score[m_player] < 99) ? m_score[m_player] + 1 : 99;
    else if (ed && !ei) m_score[m_player] = (m_score[m_player] > 0)  ? m_score[m_player] - 1 : 0;
    if (ei || ed || ec) m_show = 0;
    else if (chg)       m_show = SHOW;
    else if (m_show > 0) m_show--;
  endtask

  task automatic cycle(input bit r, input bit i, input bit d, input bit c, input bit s);
    int et, eo;
    rst = r; bus.inc_i = i; bus.dec_i = d; bus.clr_i = c; bus.player_sel_i = s;
    @(posedge clk);
    #1;
    model_step(r, i, d, c, s);
    if (m_show > 0) begin
      et = 11; eo = m_player + 1;
    end else begin
      et = (m_score[m_player] / 10 == 0) ? 10 : m_score[m_player] / 10;
      eo = m_score[m_player] % 10;
    end
    check("tens", 32'(bus.tens_o), 32'(et));
    check("ones", 32'(bus.ones_o), 32'(eo));
    check("player", 32'(bus.player_o), 32'(m_player));
  endtask

  task automatic pulse(input bit i, input bit d, input bit c, input bit s);
    cycle(0, i, d, c, s);
    cycle(0, 0, 0, 0, s);
  endtask

  initial begin
    int ptimes;
    bit r, i, d, c, s;
    rst = 1'b1; bus.inc_i = 0; bus.dec_i = 0; bus.clr_i = 0; bus.player_sel_i = 0;

    // Reset and hold
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    check("reset_tens", 32'(bus.tens_o), 32'd10);
    check("reset_ones", 32'(bus.ones_o), 32'd0);
    cycle(0, 0, 0, 0, 0);

    // 12 increments, then a held level counting once
    for (int k = 0; k < 12; k++) pulse(1, 0, 0, 0);
    check("inc12_tens", 32'(bus.tens_o), 32'd1);
    check("inc12_ones", 32'(bus.ones_o), 32'd2);
    for (int k = 0; k < 10; k++) cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    check("held_ones", 32'(bus.ones_o), 32'd3);

    // Digit carry/borrow across 09/10
    pulse(0, 0, 1, 0);
    for (int k = 0; k < 9; k++) pulse(1, 0, 0, 0);
    pulse(1, 0, 0, 0);
    check("carry_tens", 32'(bus.tens_o), 32'd1);
    pulse(0, 1, 0, 0);
    check("borrow_tens", 32'(bus.tens_o), 32'd10);
    check("borrow_ones", 32'(bus.ones_o), 32'd9);

    // Saturation at 99 and 00
    pulse(0, 0, 1, 0);
    for (int k = 0; k < 100; k++) pulse(1, 0, 0, 0);
    check("sat99_tens", 32'(bus.tens_o), 32'd9);
    check("sat99_ones", 32'(bus.ones_o), 32'd9);
    pulse(0, 0, 1, 0);
    pulse(0, 1, 0, 0);
    check("sat00_tens", 32'(bus.tens_o), 32'd10);

    // Simultaneous events at 05
    for (int k = 0; k < 5; k++) pulse(1, 0, 0, 0);
    pulse(1, 1, 0, 0);
    check("incdec_ones", 32'(bus.ones_o), 32'd5);
    pulse(1, 0, 1, 0);
    check("clrinc_ones", 32'(bus.ones_o), 32'd0);

    // Player 1 at 07, switch to P2 and back; count indicator cycles
    for (int k = 0; k < 7; k++) pulse(1, 0, 0, 0);
    ptimes = 0;
    for (int k = 0; k < 7; k++) begin
      cycle(0, 0, 0, 0, 1);
      if (bus.tens_o == 4'd11) ptimes++;
    end
    check("p2_show_len", 32'(ptimes), 32'(SHOW));
    ptimes = 0;
    for (int k = 0; k < 7; k++) begin
      cycle(0, 0, 0, 0, 0);
      if (bus.tens_o == 4'd11) ptimes++;
    end
    check("p1_show_len", 32'(ptimes), 32'(SHOW));
    check("p1_back_ones", 32'(bus.ones_o), 32'd7);

    // Event during P2 indicator aborts it
    cycle(0, 0, 0, 0, 1);
    cycle(0, 1, 0, 0, 1);
    check("abort_tens", 32'(bus.tens_o), 32'd10);
    check("abort_ones", 32'(bus.ones_o), 32'd1);
    cycle(0, 0, 0, 0, 1);

    // Reset mid-indicator
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    check("rstshow_tens", 32'(bus.tens_o), 32'd10);
    for (int k = 0; k < 5; k++) cycle(0, 0, 0, 0, 0);

    // Randomised traffic against the reference
    s = 0;
    for (int k = 0; k < 600; k++) begin
      r = ($urandom_range(0, 79) == 0);
      i = ($urandom_range(0, 2) == 0);
      d = ($urandom_range(0, 3) == 0);
      c = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 14) == 0) s = ~s;
      cycle(r, i, d, c, s);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
